// File: rtl/ifetch.sv
// ifetch: credit-limited instruction fetch with an in-flight address queue and a decode-side FIFO.
// Define IFETCH_MISALIGN_CHK_EN to suppress misaligned requests and raise a sticky fetch_fault.
module ifetch #(
   parameter int BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] fetch_pc,
   output logic        pc_advance,
   input  logic        redirect,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic        fetch_fault
);
   localparam int AW = $clog2(BUF_DEPTH);
   localparam int W  = AW + 1;
   localparam int W1 = W + 1;
   typedef enum logic {RUN, DRAIN} state_t;
   state_t        state, state_nx;
   logic [W-1:0]  outstanding, count, drop_cnt, drop_nx;
   logic [AW-1:0] aq_wr, aq_rd, ib_wr, ib_rd;
   logic [31:0]   aq_pc   [BUF_DEPTH];
   logic [31:0]   ib_data [BUF_DEPTH];
   logic [31:0]   ib_pc   [BUF_DEPTH];
   logic          want, misalign, accepted, resp_run, push, pop;
   // Credits cover both in-flight requests and buffered words, so the buffer can never overflow.
   assign want = rst && state == RUN && !redirect && !fetch_fault &&
                 ({1'b0, outstanding} + {1'b0, count} < W1'(BUF_DEPTH));
`ifdef IFETCH_MISALIGN_CHK_EN
   assign misalign = fetch_pc[1:0] != 2'b00;
   always_ff @(posedge clk or negedge rst)
      if (!rst) fetch_fault <= 1'b0;
      else if (want && misalign) fetch_fault <= 1'b1;
`else
   assign misalign    = 1'b0;
   assign fetch_fault = 1'b0;
`endif
   assign imem_req   = want && !misalign;
   assign imem_addr  = fetch_pc;
   assign accepted   = imem_req && imem_gnt;
   assign pc_advance = accepted;
   assign resp_run   = imem_rvalid && state == RUN;
   assign push       = resp_run && !redirect;
   assign inst_valid = count != '0;
   assign pop        = inst_valid && inst_ready;
   assign inst_data  = inst_valid ? ib_data[ib_rd] : '0;
   assign inst_pc    = inst_valid ? ib_pc[ib_rd] : '0;
   always_comb begin
      state_nx = state;
      drop_nx  = drop_cnt;
      if (state == RUN && redirect) begin
         drop_nx  = outstanding - W'(imem_rvalid);
         state_nx = drop_nx != '0 ? DRAIN : RUN;
      end else if (state == DRAIN && imem_rvalid) begin
         drop_nx  = drop_cnt - W'(1);
         state_nx = drop_nx != '0 ? DRAIN : RUN;
      end
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state       <= RUN;
         drop_cnt    <= '0;
         outstanding <= '0;
         count       <= '0;
         aq_wr       <= '0;
         aq_rd       <= '0;
         ib_wr       <= '0;
         ib_rd       <= '0;
      end else begin
         state    <= state_nx;
         drop_cnt <= drop_nx;
         if (redirect) begin
            outstanding <= '0;
            count       <= '0;
            aq_wr       <= '0;
            aq_rd       <= '0;
            ib_wr       <= '0;
            ib_rd       <= '0;
         end else begin
            outstanding <= outstanding + W'(accepted) - W'(resp_run);
            count       <= count + W'(push) - W'(pop);
            if (accepted) aq_wr <= aq_wr + AW'(1);
            if (resp_run) aq_rd <= aq_rd + AW'(1);
            if (push) ib_wr <= ib_wr + AW'(1);
            if (pop) ib_rd <= ib_rd + AW'(1);
         end
      end
   always_ff @(posedge clk) begin
      if (accepted) aq_pc[aq_wr] <= fetch_pc;
      if (push) begin
         ib_data[ib_wr] <= imem_rdata;
         ib_pc[ib_wr]   <= aq_pc[aq_rd];
      end
   end
   assert property (@(posedge clk) disable iff (!rst) !(push && !pop && count == W'(BUF_DEPTH)));
endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter: BUF_DEPTH, default 2, the instruction buffer depth and the outstanding-request credit limit (legal values 2 or 4).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 fetch_pc  input  32  current fetch address, driven by the PC register.
REQ-005 pc_advance  output  1  one-cycle strobe; the PC register loads the next address when it is high.
REQ-006 redirect  input  1  taken branch/jump this cycle; the new PC target is loaded by the PC stage itself.
REQ-007 imem_req  output  1  instruction memory read request.
REQ-008 imem_addr  output  32  request address, equal to fetch_pc.
REQ-009 imem_gnt  input  1  request accepted this cycle.
REQ-010 imem_rvalid  input  1  read data valid; responses return in order, at least 1 cycle after grant.
REQ-011 imem_rdata  input  32  read data.
REQ-012 inst_valid  output  1  decode-side instruction valid.
REQ-013 inst_ready  input  1  decode accepts the instruction.
REQ-014 inst_data  output  32  instruction word.
REQ-015 inst_pc  output  32  address of inst_data.
REQ-016 fetch_fault  output  1  sticky misaligned-fetch flag (see Configuration).

Function
REQ-017 Handshakes: request accepted = imem_req & imem_gnt; instruction popped = inst_valid & inst_ready.
REQ-018 pc_advance shall equal request accepted, combinationally, so the PC moves exactly once per granted request.
REQ-019 Credits: imem_req shall be 1 only when state = RUN, redirect = 0, fetch_fault = 0, and outstanding + buffered < BUF_DEPTH.
REQ-020 imem_req shall stay high with a stable imem_addr until granted, unless a redirect intervenes.
REQ-021 Each accepted request shall push fetch_pc into an in-flight address queue of depth BUF_DEPTH.
REQ-022 Each response in RUN shall pop the address queue and push {rdata, pc} into the FIFO instruction buffer.
REQ-023 The buffer shall drive inst_valid, inst_data and inst_pc from the head entry, registered, with no combinational path from imem_rdata.
REQ-024 Simultaneous push and pop shall be legal at any occupancy, including full; occupancy is then unchanged.
REQ-025 The credit rule makes buffer overflow impossible; a push to a full buffer without a pop is an assertion failure.
REQ-026 States: RUN and DRAIN.
REQ-027 On redirect: clear the buffer and the address queue in that cycle, and load drop_cnt = outstanding minus any response arriving that cycle.
REQ-028 On redirect, go to DRAIN if drop_cnt > 0, otherwise stay in RUN.
REQ-029 DRAIN: each response decrements drop_cnt and is discarded; when the last one drops, return to RUN, with no request issued in DRAIN.
REQ-030 A redirect while in DRAIN shall keep DRAIN and leave drop_cnt unchanged.
REQ-031 inst_valid shall be 0 in the cycle after redirect; a pop coinciding with redirect is still accepted by decode.
REQ-032 Counters shall be width clog2(BUF_DEPTH)+1 and shall never wrap.

Reset
REQ-033 While rst = 0: state = RUN, buffer and queue empty, outstanding = drop_cnt = 0, all outputs 0 except imem_addr = fetch_pc.
REQ-034 Reset mid-transaction drops pending responses; the memory side shall be reset together with this block.

Configuration
REQ-035 With IFETCH_MISALIGN_CHK_EN defined: fetch_pc[1:0] != 0 while requesting shall suppress the request and pc_advance, and set fetch_fault, held until reset.
REQ-036 Without the macro: no check is made, fetch_fault is tied 0, and imem_addr passes fetch_pc unmodified.

Verification
REQ-037 Zero-wait memory, inst_ready = 1, fetch_pc 0,4,8 -> inst_pc 0,4,8 in order, with one pc_advance per grant.
REQ-038 inst_ready = 0, BUF_DEPTH = 2 -> exactly 2 grants, then imem_req = 0 until a pop.
REQ-039 Redirect with 2 outstanding -> DRAIN, 2 responses dropped, inst_valid = 0, first new request after drop_cnt = 0.
REQ-040 Push and pop together on a full buffer -> occupancy stays 2, data order preserved.
REQ-041 fetch_pc = 0x102 with the macro -> fetch_fault = 1, no request issued, PC frozen; without the macro -> request issued at 0x102.
REQ-042 rst low mid-DRAIN -> all outputs and counters 0 asynchronously; normal fetch resumes after rst is released.
